// File: rtl/rheed_pkg.sv
// Types and constants shared by the RHEED crop/normalise stage and the channel packer.
package rheed_pkg;

    localparam int PIXEL_BIT_WIDTH = 10;
    localparam int OUT_ROWS        = 20;
    localparam int OUT_COLS        = 20;
    localparam int NUM_CROPS       = 3;
    localparam int CROP_PIXELS     = OUT_ROWS * OUT_COLS;

    typedef logic [PIXEL_BIT_WIDTH-1:0] pixel_t;

    // Width of one channel-interleaved output beat.
    function automatic int beat_width(input int num_crops, input int pixel_bits);
        return num_crops * pixel_bits;
    endfunction

endpackage

// File: rtl/crop_channel_packer_if.sv
// Per-crop input streams and the packed output stream of the channel packer.
interface crop_channel_packer_if
    import rheed_pkg::*;
#(
    parameter int NUM_CROPS       = 3,
    parameter int PIXEL_BIT_WIDTH = 10
);
    logic [NUM_CROPS-1:0]       s_axis_tvalid;
    logic [NUM_CROPS-1:0]       s_axis_tready;
    logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata [NUM_CROPS];

    logic                                               m_axis_tvalid;
    logic                                               m_axis_tready;
    logic [beat_width(NUM_CROPS, PIXEL_BIT_WIDTH)-1:0]  m_axis_tdata;
    logic                                               m_axis_tuser;
    logic                                               m_axis_tlast;

    // slave: the packer; master: whoever feeds crops and consumes beats
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );
endinterface

// File: rtl/crop_fifo.sv
// Synchronous circular buffer for one crop; registered read data doubles as the output beat slice.
module crop_fifo #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_ready;
    logic             w_wr;
    logic             w_rd;
    logic [AW:0]      w_count_next;

    assign w_wr = wr_valid & r_ready;
    assign w_rd = rd_en & (r_count != '0);

    always_comb begin
        w_count_next = r_count;
        if (w_wr && !w_rd) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_wr && w_rd) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Ready is registered from the next count, so it ignores a read in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
            r_ready   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != (AW+1)'(DEPTH));
        end
    end

    assign wr_ready = r_ready;
    assign rd_data  = r_rd_data;
    assign full     = (r_count == (AW+1)'(DEPTH));
    assign empty    = (r_count == '0);
endmodule

// File: rtl/crop_channel_packer.sv
// Buffers each crop stream and emits one channel-interleaved beat per pixel index with frame markers.
module crop_channel_packer
    import rheed_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int OUT_ROWS        = 20,
    parameter int OUT_COLS        = 20,
    parameter int NUM_CROPS       = 3,
    parameter int FIFO_DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    crop_channel_packer_if.slave  bus,
    output logic                  frame_done,
    output logic                  stall_err
);
    localparam int FRAME_BEATS = OUT_ROWS * OUT_COLS;
    localparam int CNT_W       = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

    logic [NUM_CROPS-1:0]       w_full;
    logic [NUM_CROPS-1:0]       w_empty;
    logic [NUM_CROPS-1:0]       w_ready;
    logic [PIXEL_BIT_WIDTH-1:0] w_rd_data [NUM_CROPS];
    logic                       w_load;

    logic             r_tvalid;
    logic             r_tuser;
    logic             r_tlast;
    logic             r_frame_done;
    logic             r_stall_err;
    logic [CNT_W-1:0] r_beat_cnt;

    // All channels must be present before a beat forms; every FIFO is popped together.
    assign w_load = (&(~w_empty)) & (!r_tvalid | bus.m_axis_tready);

    generate
        for (genvar gi = 0; gi < NUM_CROPS; gi++) begin : g_crop
            crop_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (PIXEL_BIT_WIDTH)
            ) u_fifo (
                .clk      (clk),
                .reset    (reset),
                .wr_valid (bus.s_axis_tvalid[gi]),
                .wr_data  (bus.s_axis_tdata[gi]),
                .wr_ready (w_ready[gi]),
                .rd_en    (w_load),
                .rd_data  (w_rd_data[gi]),
                .full     (w_full[gi]),
                .empty    (w_empty[gi])
            );
            assign bus.m_axis_tdata[gi*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = w_rd_data[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tvalid     <= 1'b0;
            r_tuser      <= 1'b0;
            r_tlast      <= 1'b0;
            r_frame_done <= 1'b0;
            r_stall_err  <= 1'b0;
            r_beat_cnt   <= '0;
        end else begin
            r_frame_done <= r_tvalid & bus.m_axis_tready & r_tlast;
            if (w_load) begin
                r_tvalid   <= 1'b1;
                r_tuser    <= (r_beat_cnt == '0);
                r_tlast    <= (r_beat_cnt == LAST_BEAT);
                r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
            end else if (r_tvalid && bus.m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
            // A full crop can never drain while another crop has nothing to pair with it.
            if ((|w_full) && (|w_empty)) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    assign bus.s_axis_tready = w_ready;
    assign bus.m_axis_tvalid = r_tvalid;
    assign bus.m_axis_tuser  = r_tuser;
    assign bus.m_axis_tlast  = r_tlast;
    assign frame_done        = r_frame_done;
    assign stall_err         = r_stall_err;
endmodule

// File: tb/tb_crop_channel_packer.sv
// Directed bench for crop_channel_packer with a 2x2 frame, three crops and 4-deep FIFOs.
module tb_crop_channel_packer;
    localparam int PW = 10;
    localparam int NC = 3;

    logic clk;
    logic reset;
    logic frame_done;
    logic stall_err;
    int   n_checks;
    int   n_fail;

    crop_channel_packer_if #(.NUM_CROPS(NC), .PIXEL_BIT_WIDTH(PW)) bus ();

    crop_channel_packer #(
        .PIXEL_BIT_WIDTH (PW),
        .OUT_ROWS        (2),
        .OUT_COLS        (2),
        .NUM_CROPS       (NC),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .frame_done (frame_done),
        .stall_err  (stall_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [29:0] pk(input int c0, input int c1, input int c2);
        return {10'(c2), 10'(c1), 10'(c0)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int c0, input int c1, input int c2,
                            input logic u, input logic l);
        $display("beat %s: tvalid=%0b tdata=%0h tuser=%0b tlast=%0b", tag,
                 bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast);
        chk({tag, ".tvalid"}, 64'(bus.m_axis_tvalid), 64'(1));
        chk({tag, ".tdata"},  64'(bus.m_axis_tdata),  64'(pk(c0, c1, c2)));
        chk({tag, ".tuser"},  64'(bus.m_axis_tuser),  64'(u));
        chk({tag, ".tlast"},  64'(bus.m_axis_tlast),  64'(l));
    endtask

    // Present inputs for one clock edge, return at the following negedge.
    task automatic drive(input logic [2:0] v, input int d0, input int d1, input int d2);
        bus.s_axis_tvalid   = v;
        bus.s_axis_tdata[0] = 10'(d0);
        bus.s_axis_tdata[1] = 10'(d1);
        bus.s_axis_tdata[2] = 10'(d2);
        @(negedge clk);
        bus.s_axis_tvalid = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".tvalid"},     64'(bus.m_axis_tvalid), 64'(0));
        chk({tag, ".tdata"},      64'(bus.m_axis_tdata),  64'(0));
        chk({tag, ".tuser"},      64'(bus.m_axis_tuser),  64'(0));
        chk({tag, ".tlast"},      64'(bus.m_axis_tlast),  64'(0));
        chk({tag, ".frame_done"}, 64'(frame_done),        64'(0));
        chk({tag, ".stall_err"},  64'(stall_err),         64'(0));
        chk({tag, ".s_tready"},   64'(bus.s_axis_tready), 64'(0));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.m_axis_tready   = 1'b1;
        bus.s_axis_tvalid   = '0;
        bus.s_axis_tdata[0] = '0;
        bus.s_axis_tdata[1] = '0;
        bus.s_axis_tdata[2] = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("rst.ready_after", 64'(bus.s_axis_tready), 64'(3'b111));

        // Staggered crops
        for (int k = 1; k <= 4; k++) drive(3'b001, k, 0, 0);
        chk("stag.c0_full_ready", 64'(bus.s_axis_tready), 64'(3'b110));
        for (int k = 11; k <= 14; k++) drive(3'b010, 0, k, 0);
        drive(3'b100, 0, 0, 21);
        chk("stag.no_beat_yet", 64'(bus.m_axis_tvalid), 64'(0));
        drive(3'b100, 0, 0, 22);
        chk_beat("stag.b0", 1, 11, 21, 1'b1, 1'b0);
        drive(3'b100, 0, 0, 23);
        chk_beat("stag.b1", 2, 12, 22, 1'b0, 1'b0);
        drive(3'b100, 0, 0, 24);
        chk_beat("stag.b2", 3, 13, 23, 1'b0, 1'b0);
        drive(3'b000, 0, 0, 0);
        chk_beat("stag.b3", 4, 14, 24, 1'b0, 1'b1);
        chk("stag.fd_early", 64'(frame_done), 64'(0));
        drive(3'b000, 0, 0, 0);
        chk("stag.tvalid_drop", 64'(bus.m_axis_tvalid), 64'(0));
        chk("stag.fd_pulse", 64'(frame_done), 64'(1));
        drive(3'b000, 0, 0, 0);
        chk("stag.fd_one_cycle", 64'(frame_done), 64'(0));
        apply_reset();

        // Latency: last missing channel arrives at edge E
        drive(3'b011, 61, 71, 0);
        drive(3'b100, 0, 0, 81);
        chk("lat.after_E", 64'(bus.m_axis_tvalid), 64'(0));
        drive(3'b000, 0, 0, 0);
        chk_beat("lat.after_E1", 61, 71, 81, 1'b1, 1'b0);
        apply_reset();

        // Backpressure
        bus.m_axis_tready = 1'b0;
        for (int k = 1; k <= 4; k++) drive(3'b111, 100 + k, 110 + k, 120 + k);
        chk_beat("bp.b0_held", 101, 111, 121, 1'b1, 1'b0);
        bus.m_axis_tready = 1'b1;
        drive(3'b000, 0, 0, 0);
        chk_beat("bp.b1", 102, 112, 122, 1'b0, 1'b0);
        bus.m_axis_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(3'b000, 0, 0, 0);
            chk_beat($sformatf("bp.b1_stall%0d", k), 102, 112, 122, 1'b0, 1'b0);
        end
        bus.m_axis_tready = 1'b1;
        drive(3'b000, 0, 0, 0);
        chk_beat("bp.b2", 103, 113, 123, 1'b0, 1'b0);
        drive(3'b000, 0, 0, 0);
        chk_beat("bp.b3", 104, 114, 124, 1'b0, 1'b1);
        drive(3'b000, 0, 0, 0);
        chk("bp.tvalid_drop", 64'(bus.m_axis_tvalid), 64'(0));
        chk("bp.fd_pulse", 64'(frame_done), 64'(1));
        apply_reset();

        // Full FIFO and deadlock flag
        for (int k = 1; k <= 4; k++) drive(3'b001, 200 + k, 0, 0);
        chk("full.ready0_low", 64'(bus.s_axis_tready), 64'(3'b110));
        chk("full.stall_not_yet", 64'(stall_err), 64'(0));
        drive(3'b001, 205, 0, 0);
        chk("full.ready0_held", 64'(bus.s_axis_tready), 64'(3'b110));
        chk("full.stall_set", 64'(stall_err), 64'(1));
        drive(3'b000, 0, 0, 0);
        drive(3'b000, 0, 0, 0);
        chk("full.stall_sticky", 64'(stall_err), 64'(1));
        chk("full.no_beat", 64'(bus.m_axis_tvalid), 64'(0));
        drive(3'b110, 0, 301, 401);
        drive(3'b000, 0, 0, 0);
        chk_beat("full.first_out", 201, 301, 401, 1'b1, 1'b0);
        chk("full.ready0_back", 64'(bus.s_axis_tready), 64'(3'b111));
        chk("full.stall_still", 64'(stall_err), 64'(1));
        apply_reset();
        chk("full.stall_cleared", 64'(stall_err), 64'(0));

        // Reset mid-frame
        drive(3'b111, 1, 11, 21);
        drive(3'b111, 2, 12, 22);
        chk_beat("mid.b0", 1, 11, 21, 1'b1, 1'b0);
        drive(3'b000, 0, 0, 0);
        chk_beat("mid.b1", 2, 12, 22, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("mid.rst");
        reset = 1'b0;
        @(negedge clk);
        drive(3'b111, 31, 41, 51);
        chk("mid.new_not_yet", 64'(bus.m_axis_tvalid), 64'(0));
        drive(3'b111, 32, 42, 52);
        chk_beat("mid.n0", 31, 41, 51, 1'b1, 1'b0);
        drive(3'b111, 33, 43, 53);
        chk_beat("mid.n1", 32, 42, 52, 1'b0, 1'b0);
        drive(3'b111, 34, 44, 54);
        chk_beat("mid.n2", 33, 43, 53, 1'b0, 1'b0);
        drive(3'b000, 0, 0, 0);
        chk_beat("mid.n3", 34, 44, 54, 1'b0, 1'b1);
        drive(3'b000, 0, 0, 0);
        chk("mid.fd_pulse", 64'(frame_done), 64'(1));

        // Back-to-back frames
        for (int k = 1; k <= 8; k++) begin
            drive(3'b111, 60 + k, 70 + k, 80 + k);
            if (k >= 2) begin
                chk_beat($sformatf("b2b.b%0d", k - 2), 60 + k - 1, 70 + k - 1, 80 + k - 1,
                         ((k - 2) % 4) == 0, ((k - 2) % 4) == 3);
                chk($sformatf("b2b.fd%0d", k - 2), 64'(frame_done), 64'(k == 6));
            end
        end
        drive(3'b000, 0, 0, 0);
        chk_beat("b2b.b7", 68, 78, 88, 1'b0, 1'b1);
        chk("b2b.fd7", 64'(frame_done), 64'(0));
        drive(3'b000, 0, 0, 0);
        chk("b2b.tvalid_drop", 64'(bus.m_axis_tvalid), 64'(0));
        chk("b2b.fd_second", 64'(frame_done), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/crop_channel_packer.md
Name: crop_channel_packer

Overview:
- Consumes the NUM_CROPS independent per-crop pixel streams leaving the crop/normalise stage of the RHEED inference path.
- Crops finish at different times within a frame, so the block buffers each crop in its own FIFO.
- Emits one channel-interleaved stream: each beat holds the same pixel index from every crop.
- This is the NUM_CROPS-channel input format of the downstream inference engine, with start-of-frame and end-of-frame markers.

Parameters:
- PIXEL_BIT_WIDTH, 10: width of one normalised pixel.
- OUT_ROWS, 20: rows per crop.
- OUT_COLS, 20: columns per crop.
- NUM_CROPS, 3: number of crop streams/channels.
- FIFO_DEPTH, 512: entries per crop FIFO. Must be a power of two and >= OUT_ROWS*OUT_COLS.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  NUM_CROPS  per-crop input valid.
- s_axis_tready  out  NUM_CROPS  per-crop input ready.
- s_axis_tdata  in  PIXEL_BIT_WIDTH x [NUM_CROPS] (unpacked array)  per-crop pixel.
- m_axis_tvalid  out  1  packed beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  NUM_CROPS*PIXEL_BIT_WIDTH  crop i occupies bits [i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH].
- m_axis_tuser  out  1  high on the first beat of a frame.
- m_axis_tlast  out  1  high on beat OUT_ROWS*OUT_COLS-1.
- frame_done  out  1  one-cycle pulse after the last beat's handshake.
- stall_err  out  1  sticky deadlock flag.

Behaviour:
- Reset: FIFOs emptied, pointers/counts = 0, beat counter = 0. m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, stall_err and m_axis_tdata all = 0. s_axis_tready = 0 while reset is high, then 1 from the next cycle. Reset mid-frame discards all buffered data; the next beat emitted carries tuser=1.
- Input side: s_axis_tready[i] = !full[i], registered from the count; it does not account for a same-cycle read. A write occurs on s_axis_tvalid[i] & s_axis_tready[i]. Crops are fully independent.
- Output register: one stage, loaded by synchronous read mem[rd_ptr] of every FIFO (BRAM-friendly).
  - load = (all FIFOs non-empty) & (!m_axis_tvalid | m_axis_tready).
  - On load, every rd_ptr advances by 1 simultaneously.
  - Otherwise, on a handshake, m_axis_tvalid drops.
- Without m_axis_tready stalls, throughput is 1 beat/cycle.
- m_axis_tdata, tuser and tlast are held stable while tvalid & !tready.
- Latency: a pixel accepted at edge E becomes readable after E (count updated). If it is the last missing channel, the output loads at E+1, so m_axis_tvalid is high after E+1 (2 cycles). A write to an empty FIFO is never readable in the same cycle.
- Beat counter: counts 0..OUT_ROWS*OUT_COLS-1 and advances on each output load.
  - tuser = (counter == 0) at load.
  - tlast = (counter == last) at load.
  - The counter wraps to 0 after the last index.
  - frame_done pulses the cycle after the tlast handshake.
- Simultaneous read/write on the same FIFO: count unchanged, pointers both advance. On a full FIFO the write is refused (ready already low), and the read proceeds.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Count is $clog2(FIFO_DEPTH)+1 bits.
- stall_err: set when any FIFO is full while any other FIFO is empty (unresolvable deadlock). Cleared only by reset. It does not alter the datapath.

Decomposition:
- Package rheed_pkg:
  - localparam CROP_PIXELS = OUT_ROWS*OUT_COLS.
  - pixel_t (logic [PIXEL_BIT_WIDTH-1:0]).
  - Packed-beat width function.
  - Shared with the crop/normalise stage.
- Sub-module crop_fifo:
  - Synchronous circular buffer, DEPTH/WIDTH parameters, registered read data.
  - Provides full/empty/count.
  - Instantiated NUM_CROPS times in a generate loop.
- The top holds the output register, beat counter, marker logic and stall detector.

Test Plan:
Bench parameters: OUT_ROWS=2, OUT_COLS=2, NUM_CROPS=3, FIFO_DEPTH=4, PIXEL_BIT_WIDTH=10, m_axis_tready=1 unless stated.
- Staggered crops: crop0 sends 1,2,3,4, then crop1 11..14, then crop2 21..24 -> 4 beats, tdata = {21,11,1}, {22,12,2}, {23,13,3}, {24,14,4}; tuser on beat 0 only, tlast on beat 3, frame_done one cycle after beat 3.
- Latency: crop0/1 preloaded, crop2 pixel accepted at edge E -> m_axis_tvalid first high after E+1, with the correct packed value.
- Backpressure: drop m_axis_tready for 5 cycles after beat 1 -> tdata/tuser/tlast stable, no loss or duplication, remaining beats in order.
- Full/deadlock: crop0 sends 5 pixels, others idle -> s_axis_tready[0]=0 after 4 accepted, 5th held, stall_err=1 and stays 1; reset clears it.
- Reset mid-frame: reset for 1 cycle after 2 beats -> all outputs 0. New frame {31..34},{41..44},{51..54} -> first beat {51,41,31} with tuser=1.
- Back-to-back: two frames with all inputs streaming continuously -> 8 beats on consecutive cycles, tlast on beats 3 and 7, two frame_done pulses.
